// File: rtl/dac_frame_scheduler_pkg.sv
// Shared types and frame layout for the DAC frame scheduler.
// Frame word: {ch[1:0], ctrl[1:0], sample[11:0]}.
package dac_frame_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_HOLD,
    S_DONE
  } state_t;

  localparam int FRAME_W  = 16;
  localparam int CH_MSB   = 15;
  localparam int CTRL_MSB = 13;
  localparam int DATA_MSB = 11;

  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [1:0]        ch,
    input logic [1:0]        ctrl,
    input logic [DATA_MSB:0] smp
  );
    logic [FRAME_W-1:0] f;
    f                  = '0;
    f[CH_MSB -: 2]     = ch;
    f[CTRL_MSB -: 2]   = ctrl;
    f[DATA_MSB:0]      = smp;
    return f;
  endfunction

endpackage

// File: rtl/dac_frame_scheduler_if.sv
// Requester + serializer bundle of the DAC frame scheduler.
// slave: scheduler side; master: requester/serializer side.
interface dac_frame_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 12
);
  logic                     key_state;
  logic [NUM_CH-1:0]        req;
  logic [NUM_CH*DATA_W-1:0] sample;
  logic [NUM_CH-1:0]        ack;
  logic                     busy;
  logic                     en_dac;
  logic [15:0]              data_sdi;
  logic                     cs;
  logic                     sck;
  logic [4:0]               cnt_sck;

  modport slave (
    input  key_state, req, sample,
    output ack, busy, en_dac, data_sdi,
    output cs, sck, cnt_sck
  );

  modport master (
    output key_state, req, sample,
    input  ack, busy, en_dac, data_sdi,
    input  cs, sck, cnt_sck
  );
endinterface

// File: rtl/dac_frame_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first req at/after i_ptr.
// Ports: i_req, i_ptr -> o_valid, o_gnt (one-hot), o_idx.
module dac_frame_scheduler_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [IDX_W-1:0]  i_ptr,
  output logic              o_valid,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [IDX_W-1:0]  o_idx
);

  logic [IDX_W-1:0] w_pos;

  // Scan from the farthest offset down so the
  // nearest hit to the pointer wins.
  always_comb begin
    o_valid = 1'b0;
    o_gnt   = '0;
    o_idx   = '0;
    w_pos   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      w_pos = i_ptr + IDX_W'(i);
      if (i_req[w_pos]) begin
        o_valid      = 1'b1;
        o_idx        = w_pos;
        o_gnt        = '0;
        o_gnt[w_pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac_frame_scheduler.sv
// Round-robin scheduler sharing one 16-bit DAC serializer.
// Ports: clk, rst_n, bus (req/sample/key_state in; ack/busy/en_dac/data_sdi/cs/sck/cnt_sck out).
module dac_frame_scheduler
  import dac_frame_scheduler_pkg::*;
#(
  parameter int         NUM_CH   = 4,
  parameter int         DATA_W   = 12,
  parameter logic [1:0] CTRL     = 2'b01,
  parameter int         SCK_HALF = 2,
  parameter int         GAP_CYC  = 12
) (
  input logic                  clk,
  input logic                  rst_n,
  dac_frame_scheduler_if.slave bus
);

  localparam int IDX_W  = $clog2(NUM_CH);
  localparam int HALF_W = $clog2(SCK_HALF);
  localparam int GAP_W  = $clog2(GAP_CYC + 1);

  state_t r_state, w_next;

  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_gidx;
  logic [NUM_CH-1:0]  r_gnt;
  logic [HALF_W-1:0]  r_half;
  logic               r_sck_hi;
  logic [4:0]         r_cnt;
  logic [GAP_W-1:0]   r_gap;
  logic [FRAME_W-1:0] r_frame;

  logic               w_gvalid;
  logic [NUM_CH-1:0]  w_gnt;
  logic [IDX_W-1:0]   w_gidx;
  logic [1:0]         w_ch;
  logic [DATA_W-1:0]  w_samp [NUM_CH];
  logic               w_half_end;
  logic               w_shift_end;
  logic               w_gap_end;
  logic               w_grant;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_samp
    assign w_samp[gi] = bus.sample[gi*DATA_W +: DATA_W];
  end

  dac_frame_scheduler_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_valid (w_gvalid),
    .o_gnt   (w_gnt),
    .o_idx   (w_gidx)
  );

  assign w_ch       = 2'(w_gidx);
  assign w_half_end = (r_half == HALF_W'(SCK_HALF - 1));
  // Last high->low edge of sck: bit 16 completes.
  assign w_shift_end = w_half_end && r_sck_hi
                    && (r_cnt == 5'd15);
  assign w_gap_end  = (r_gap == GAP_W'(GAP_CYC - 1));
  assign w_grant    = (r_state == S_IDLE)
                   && (w_next == S_LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!bus.key_state) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (w_gvalid) w_next = S_LOAD;
        S_LOAD:  w_next = S_SHIFT;
        S_SHIFT: if (w_shift_end) w_next = S_HOLD;
        S_HOLD:  if (w_gap_end) w_next = S_DONE;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_gidx   <= '0;
      r_gnt    <= '0;
      r_half   <= '0;
      r_sck_hi <= 1'b0;
      r_cnt    <= '0;
      r_gap    <= '0;
      r_frame  <= '0;
    end else begin
      if (w_grant) begin
        r_gidx  <= w_gidx;
        r_gnt   <= w_gnt;
        r_frame <= build_frame(w_ch, CTRL,
                               w_samp[w_gidx]);
      end
      if (r_state == S_DONE)
        r_ptr <= r_gidx + IDX_W'(1);
      if (r_state == S_SHIFT && w_next == S_SHIFT) begin
        if (w_half_end) begin
          r_half   <= '0;
          r_sck_hi <= ~r_sck_hi;
        end else begin
          r_half <= r_half + HALF_W'(1);
        end
      end else begin
        r_half   <= '0;
        r_sck_hi <= 1'b0;
      end
      if (w_next == S_IDLE || w_next == S_LOAD)
        r_cnt <= '0;
      else if (r_state == S_SHIFT && w_half_end
               && r_sck_hi)
        r_cnt <= r_cnt + 5'd1;
      if (r_state == S_HOLD && w_next == S_HOLD)
        r_gap <= r_gap + GAP_W'(1);
      else
        r_gap <= '0;
    end
  end

  always_comb begin
    bus.en_dac   = (r_state == S_LOAD);
    bus.cs       = (r_state != S_SHIFT);
    bus.sck      = (r_state == S_SHIFT) && r_sck_hi;
    bus.busy     = (r_state != S_IDLE);
    bus.ack      = (r_state == S_DONE) ? r_gnt : '0;
    bus.data_sdi = r_frame;
    bus.cnt_sck  = r_cnt;
  end

endmodule
